// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow-memory line port between the I-cache and the
// D-cache. In IDLE the request of one cache is latched into registered mem_*
// outputs and the block moves to BUSY. In BUSY the latched command is held
// and mem_ready is routed only to the cache that won. The IDLE cycle after
// each completion is the guaranteed idle gap before the next grant.
//
// Ports
//   clk, rst_n                      clock and asynchronous active-low reset
//   i_read/i_write/i_addr/i_wdata   I-cache request; held until i_ready
//   i_rdata, i_ready                read line and completion pulse to I-cache
//   d_read/d_write/d_addr/d_wdata   D-cache request; held until d_ready
//   d_rdata, d_ready                read line and completion pulse to D-cache
//   mem_read/mem_write/mem_addr/mem_wdata   registered command to memory
//   mem_rdata, mem_ready            read line and completion pulse from memory
//   owner                           current or last grant (0 = I, 1 = D)
//
// Parameters
//   D_PRIO     1: D wins simultaneous requests (see MAX_D_RUN); 0: alternate
//   MAX_D_RUN  most D grants in a row while I is waiting, when D_PRIO = 1
module mem_arbiter #(
  parameter int D_PRIO    = 1,
  parameter int MAX_D_RUN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [27:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_ready,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [27:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_ready,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic         owner
);

  localparam int RUN_W = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } req_t;

  state_t           state, state_nxt;
  req_t             req_i, req_d, req_win;
  logic             i_pend, d_pend, any_pend, win_d;
  logic [RUN_W-1:0] run_cnt;

  assign req_i    = {i_read, i_write, i_addr, i_wdata};
  assign req_d    = {d_read, d_write, d_addr, d_wdata};
  assign i_pend   = i_read | i_write;
  assign d_pend   = d_read | d_write;
  assign any_pend = i_pend | d_pend;

  // Winner selection. It is only used in IDLE while something is pending.
  // When one side is pending alone, that side wins.
  always_comb begin
    win_d = d_pend;
    if (i_pend && d_pend) begin
      if (D_PRIO != 0) win_d = (run_cnt != RUN_W'(MAX_D_RUN));
      else             win_d = ~owner;
    end
  end

  assign req_win = win_d ? req_d : req_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_pend)  state_nxt = BUSY;
      BUSY: if (mem_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Outputs. Ready is combinational from mem_ready and reaches only the
  // owner. In IDLE, mem_ready is ignored.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    if (state == BUSY) begin
      i_ready = mem_ready & ~owner;
      d_ready = mem_ready &  owner;
    end
  end

  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Registered memory command. A write takes precedence over a read that is
  // raised in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
    end else if (state == IDLE && any_pend) begin
      mem_addr  <= req_win.addr;
      mem_wdata <= req_win.wdata;
      mem_write <= req_win.wr;
      mem_read  <= req_win.rd & ~req_win.wr;
      owner     <= win_d;
    end else if (state == BUSY && mem_ready) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end
  end

  // Starvation guard. This counts D grants that were made while I was
  // waiting. It is cleared by an I grant, or by any IDLE cycle in which I is
  // not pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_pend)
        run_cnt <= '0;
      else if (d_pend && win_d) begin
        if (run_cnt != RUN_W'(MAX_D_RUN)) run_cnt <= run_cnt + 1'b1;
      end else
        run_cnt <= '0;
    end
  end

endmodule
